// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operand width,
// iteration counter width, R-type Funct codes and the sequencer states.
package muldiv_ctrl_pkg;

    // Operand and HI/LO width.
    localparam int XLEN  = 32;
    // Iteration counter width; 2**CNT_W must exceed XLEN.
    localparam int CNT_W = 6;

    // Funct codes (Ins[5:0]) also decoded by the EX ALU.
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    // True for the four instructions that start an iterative operation.
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    // True for every instruction that touches HI/LO and must wait while busy.
    function automatic logic is_hilo_op(input logic [5:0] f);
        return is_muldiv(f) ||
               (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
               (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bus between the EX stage (master) and the HI/LO unit (slave).
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic            Valid;
    logic [5:0]      Funct;
    logic [XLEN-1:0] Rdata1;
    logic [XLEN-1:0] Rdata2;
    logic            Busy;
    logic            Done;
    logic            Stall;
    logic [XLEN-1:0] Hi;
    logic [XLEN-1:0] Lo;
    logic [XLEN-1:0] MfData;

    modport master (
        output Valid, Funct, Rdata1, Rdata2,
        input  Busy, Done, Stall, Hi, Lo, MfData
    );

    modport slave (
        input  Valid, Funct, Rdata1, Rdata2,
        output Busy, Done, Stall, Hi, Lo, MfData
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shared datapath: shift-add multiply step or
// restoring divide step, selected by is_div_i. Purely combinational.
module muldiv_step
    import muldiv_ctrl_pkg::*;
(
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,    // mul: partial product; div: {rem, quo}
    input  logic [XLEN-1:0]   opb_i,    // mul: multiplicand; div: divisor
    input  logic [XLEN-1:0]   mplr_i,   // mul: remaining multiplier bits
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   mplr_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            fits;

    // Compute both step flavours and select the one for the current operation.
    always_comb begin
        // Multiply: conditionally add the multiplicand to the upper half, then
        // shift the whole accumulator right with the carry entering the top.
        sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (mplr_i[0] ? {1'b0, opb_i} : '0);
        // Divide: bring the next dividend bit into the remainder and try the
        // subtraction; the true difference always fits XLEN bits when it succeeds.
        shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        fits    = (shifted >= {1'b0, opb_i});
        sub     = shifted[XLEN-1:0] - opb_i;

        if (is_div_i) begin
            acc_o  = {(fits ? sub : shifted[XLEN-1:0]), acc_i[XLEN-2:0], fits};
            mplr_o = mplr_i;
        end else begin
            acc_o  = {sum, acc_i[XLEN-1:1]};
            mplr_o = mplr_i >> 1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO unit and sequencer for the EX stage: owns HI/LO, runs one iterative
// multiply or divide at a time and stalls HI/LO-hazard instructions meanwhile.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave the iteration as soon as
// the remaining multiplier bits are zero and are re-aligned in the FIX cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    muldiv_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;          // negate product / quotient
    logic              neg_rem_q, neg_rem_d;  // negate remainder
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   step_mplr;
    logic              op_signed, op_div;
    logic              sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              iter_last;
    logic [2*XLEN-1:0] prod_al, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    muldiv_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .mplr_i   (mplr_q),
        .acc_o    (step_acc),
        .mplr_o   (step_mplr)
    );

    // Operand decode, iteration exit test and final sign correction.
    always_comb begin
        op_signed = (bus.Funct == FUNCT_MULT) || (bus.Funct == FUNCT_DIV);
        op_div    = (bus.Funct == FUNCT_DIV)  || (bus.Funct == FUNCT_DIVU);
        sign1     = op_signed & bus.Rdata1[XLEN-1];
        sign2     = op_signed & bus.Rdata2[XLEN-1];
        mag1      = sign1 ? (~bus.Rdata1 + 1'b1) : bus.Rdata1;
        mag2      = sign2 ? (~bus.Rdata2 + 1'b1) : bus.Rdata2;
`ifdef MULDIV_EARLY_OUT_EN
        iter_last = (cnt_q == CNT_W'(XLEN-1)) || (!is_div_q && (step_mplr == '0));
        // Each skipped step would only have shifted right by one.
        prod_al   = acc_q >> (CNT_W'(XLEN-1) - cnt_q);
`else
        iter_last = (cnt_q == CNT_W'(XLEN-1));
        prod_al   = acc_q;
`endif
        prod_fix  = neg_q     ? (~prod_al + 1'b1) : prod_al;
        quo_fix   = neg_q     ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    // Next-state logic for the sequencer, scratch registers and HI/LO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        mplr_d    = mplr_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.Valid) begin
                    if (bus.Funct == FUNCT_MTHI) begin
                        hi_d = bus.Rdata2;
                    end else if (bus.Funct == FUNCT_MTLO) begin
                        lo_d = bus.Rdata2;
                    end else if (is_muldiv(bus.Funct)) begin
                        is_div_d  = op_div;
                        cnt_d     = '0;
                        neg_d     = sign1 ^ sign2;
                        neg_rem_d = sign1;
                        state_d   = ITER;
                        if (op_div) begin
                            acc_d  = {{XLEN{1'b0}}, mag1};
                            opb_d  = mag2;
                            mplr_d = '0;
                            if (bus.Rdata2 == '0) begin
                                // Divide by zero: fixed result, no iteration
                                // and no sign correction.
                                acc_d     = {bus.Rdata1, {XLEN{1'b1}}};
                                neg_d     = 1'b0;
                                neg_rem_d = 1'b0;
                                state_d   = FIX;
                            end
                        end else begin
                            acc_d  = '0;
                            opb_d  = mag1;
                            mplr_d = mag2;
                        end
                    end
                end
            end
            ITER: begin
                acc_d  = step_acc;
                mplr_d = step_mplr;
                if (iter_last) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            mplr_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            mplr_q    <= mplr_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Outputs: Stall depends only on Busy and the presented instruction.
    assign bus.Busy   = (state_q != IDLE);
    assign bus.Done   = done_q;
    assign bus.Hi     = hi_q;
    assign bus.Lo     = lo_q;
    assign bus.Stall  = bus.Valid && (state_q != IDLE) && is_hilo_op(bus.Funct);
    assign bus.MfData = (bus.Funct == FUNCT_MFHI) ? hi_q :
                        (bus.Funct == FUNCT_MFLO) ? lo_q : '0;

endmodule
